// File: rtl/i2c_bus_cond_det_if.sv
// Pad-side and event-side signals of the I2C bus-condition detector.
// master drives pads and enable; slave is the detector itself.
interface i2c_bus_cond_det_if;
    logic en;
    logic scl_i;
    logic sda_i;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic rstart_det;
    logic stop_det;
    logic bus_busy;
    logic timeout;

    modport master (
        output en, scl_i, sda_i,
        input  scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det,
               bus_busy, timeout
    );

    modport slave (
        input  en, scl_i, sda_i,
        output scl_f, sda_f, scl_rise, scl_fall, start_det, rstart_det, stop_det,
               bus_busy, timeout
    );
endinterface

// File: rtl/i2c_bus_cond_det.sv
// Synchronise and glitch-filter SCL/SDA, then decode START/rSTART/STOP and SCL edges.
// Define I2C_BUS_TIMEOUT_EN to add the SCL-stuck-low timeout that releases bus_busy.
module i2c_bus_cond_det #(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       FILT_LEN    = 3,
    parameter int unsigned       TOUT_W      = 16,
    parameter logic [TOUT_W-1:0] TOUT_CYC    = 16'd50000
) (
    input logic               clk_i,
    input logic               rst,
    i2c_bus_cond_det_if.slave bus
);

    localparam int unsigned    CntW    = $clog2(FILT_LEN + 1);
    localparam logic [CntW-1:0] FiltMax = CntW'(FILT_LEN);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic [1:0]             sync_out;
    // Bit 0 is SCL, bit 1 is SDA.
    logic [1:0]             filt_q, filt_d;
    logic [1:0]             prev_q, prev_d;
    logic [CntW-1:0]        cnt_q [2];
    logic [CntW-1:0]        cnt_d [2];

    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic rstart_q, rstart_d;
    logic stop_q, stop_d;
    logic busy_q, busy_d;
    logic timeout_q, timeout_d;
    logic start_c, stop_c, tout_hit;

`ifdef I2C_BUS_TIMEOUT_EN
    logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;

    always_comb begin
        tout_cnt_d = '0;
        tout_hit   = 1'b0;
        if (busy_q && !filt_q[0]) begin
            if (tout_cnt_q + TOUT_W'(1) == TOUT_CYC) begin
                tout_hit = 1'b1;
            end else begin
                tout_cnt_d = tout_cnt_q + TOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst || !bus.en) begin
            tout_cnt_q <= '0;
        end else begin
            tout_cnt_q <= tout_cnt_d;
        end
    end
`else
    logic unused_tout;
    assign unused_tout = ^TOUT_CYC;
    assign tout_hit    = 1'b0;
`endif

    assign sync_out = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};
    assign start_c  = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
    assign stop_c   = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
        filt_d     = filt_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != filt_q[i]) begin
                if (cnt_q[i] + CntW'(1) == FiltMax) begin
                    filt_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end

        prev_d     = filt_q;
        scl_rise_d = filt_q[0] & ~prev_q[0];
        scl_fall_d = ~filt_q[0] & prev_q[0];
        start_d    = start_c & ~busy_q;
        rstart_d   = start_c & busy_q;
        stop_d     = stop_c;
        timeout_d  = tout_hit;

        busy_d = busy_q;
        if (start_c) begin
            busy_d = 1'b1;
        end else if (stop_c || tout_hit) begin
            busy_d = 1'b0;
        end
    end

    // Disable is treated as reset so re-enabling never produces spurious pulses.
    always_ff @(posedge clk_i) begin
        if (rst || !bus.en) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            filt_q     <= '1;
            prev_q     <= '1;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.scl_f      = filt_q[0];
    assign bus.sda_f      = filt_q[1];
    assign bus.scl_rise   = scl_rise_q;
    assign bus.scl_fall   = scl_fall_q;
    assign bus.start_det  = start_q;
    assign bus.rstart_det = rstart_q;
    assign bus.stop_det   = stop_q;
    assign bus.bus_busy   = busy_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: doc/i2c_bus_cond_det.md
# i2c_bus_cond_det

- Parametrised I2C bus-condition detector; successor to the single-mode START/STOP detector.
- Synchronises and glitch-filters raw SCL/SDA into the system clock domain.
- Detects START, repeated START and STOP; reports SCL edges and a bus-busy level; optionally detects SCL-stuck-low timeout.
- Sits between the pads and the I2C slave shift/FSM logic, which consumes its single-cycle pulses.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser flops per line (≥2)
- FILT_LEN, 3, consecutive identical synchronised samples needed to change a filtered line (≥1)
- TOUT_W, 16, timeout counter width
- TOUT_CYC, 16'd50000, SCL-low cycles while busy that trigger timeout (1..2^TOUT_W-1)

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  block enable
- scl_i  in  1  raw SCL pad input
- sda_i  in  1  raw SDA pad input
- scl_f  out  1  filtered SCL
- sda_f  out  1  filtered SDA
- scl_rise  out  1  one-cycle pulse, filtered SCL 0→1
- scl_fall  out  1  one-cycle pulse, filtered SCL 1→0
- start_det  out  1  one-cycle pulse, START while bus idle
- rstart_det  out  1  one-cycle pulse, START while bus busy (repeated START)
- stop_det  out  1  one-cycle pulse, STOP
- bus_busy  out  1  level, set by START/repeated START, cleared by STOP/timeout
- timeout  out  1  one-cycle pulse, SCL stuck low (see Configuration)

## Operation
- Reset (rst=1 at a clk_i edge): sync flops, filtered lines and their previous-sample registers = 1; filter counters = 0; all pulses, bus_busy, timeout = 0.
- en=0: every register is held at its reset value each cycle, exactly as under rst. Re-enabling behaves like release from reset, so no spurious pulse on an idle-high bus.
- Synchroniser: SYNC_STAGES-flop shift per line.
- Filter, per line: counter counts cycles where sync output ≠ filtered value and clears when they are equal. When the count reaches FILT_LEN, the filtered value takes the sync value and the counter clears. Glitches shorter than FILT_LEN cycles are discarded.
- Edge and condition decode: compares current filtered values against previous-cycle filtered values, registered.
  - START: SCL high in both samples, SDA 1→0. Asserts start_det if bus_busy=0, else rstart_det. Sets bus_busy.
  - STOP: SCL high in both samples, SDA 0→1. Asserts stop_det. Clears bus_busy. STOP while idle is still pulsed.
  - SCL and SDA changing in the same filtered cycle: no START/STOP. scl_rise/scl_fall still pulse.
- At most one of start_det/rstart_det/stop_det is high in any cycle.

## Timing
- Latency L = SYNC_STAGES + FILT_LEN + 1 cycles, from the first clk_i edge sampling the new stable pad level to pulse assertion. Default L = 6.
- scl_f/sda_f lead the pulses by exactly 1 cycle.
- All pulses are exactly 1 cycle wide; no handshake; the consumer must sample every cycle.
- bus_busy changes in the same cycle its causing pulse is high.
- rst or en=0 mid-transaction: bus_busy drops on the next edge; no stop_det is generated.

## Configuration
- Macro: I2C_BUS_TIMEOUT_EN.
- Defined:
  - TOUT_W-bit counter increments each cycle while bus_busy=1 and scl_f=0; clears otherwise.
  - When it reaches TOUT_CYC: timeout pulses 1 cycle, bus_busy clears in the same cycle, counter clears.
  - A later START is reported as start_det.
- Not defined: no counter; timeout tied to 0; bus_busy cleared only by STOP, rst or en=0.

## Test plan
Defaults unless stated; L=6.
- Reset/idle: hold scl_i=sda_i=1, pulse rst 2 cycles, then 20 cycles → all pulses 0, bus_busy=0, scl_f=sda_f=1.
- START then STOP: SCL high, SDA 1→0; 50 cycles later SDA 0→1 → start_det at +6 with bus_busy=1; stop_det at +6 after second edge with bus_busy=0.
- Repeated START: START, SCL low 20 cycles, SDA→1, SCL→1, 10 cycles, SDA→0 → rstart_det=1, start_det=0, bus_busy stays 1.
- Glitch reject:
  - 2-cycle low pulse on SDA with SCL high → no pulse, sda_f stays 1.
  - 3-cycle low pulse → start_det.
- Simultaneous edge: SCL and SDA both fall on the same edge → scl_fall only, no start_det.
- Timeout (macro defined, TOUT_CYC=100): START, then SCL held low 100+ cycles → one timeout pulse, bus_busy=0; next START gives start_det. Without the macro, timeout stays 0 and bus_busy stays 1.
